mips_cpu_fetch_unit: RTL and testbench

//  Instruction-fetch initiator of the Harvard CPU: owns the PC, drives instr_address to instruction memory,

---
 rtl/mips_cpu_pkg.sv | 18 +
 rtl/mips_cpu_pc_reg.sv | 29 ++
 rtl/mips_cpu_fetch_unit.sv | 79 +++++++
 tb/tb_mips_cpu_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types, address defaults and byte-swap helper for the Harvard CPU
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN    = 2'd0,
    FETCH_DELAY  = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

  // Memory bus words are little-endian; the datapath wants MIPS big-endian order.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_pc_reg.sv
// rtl/mips_cpu_pc_reg.sv - 32-bit program counter with load, +4 increment and hold
import mips_cpu_pkg::*;

module mips_cpu_pc_reg #(
  parameter logic [31:0] RESET_VALUE = DEF_RESET_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_load_value,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc <= RESET_VALUE;
    end else if (i_load) begin
      r_pc <= {i_load_value[31:2], 2'b00};
    end else if (i_inc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/mips_cpu_fetch_unit.sv
// rtl/mips_cpu_fetch_unit.sv - instruction fetch: PC ownership, byte swap, delay-slot and halt sequencing
import mips_cpu_pkg::*;

module mips_cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_enable,
  input  logic        i_instr_wait,
  input  logic [31:0] i_instr_readdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_instr_address,
  output logic [31:0] o_instr_word,
  output logic [31:0] o_pc_plus8,
  output logic        o_in_delay_slot,
  output logic        o_active,
  output logic        o_ds_branch_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pending;
  logic         r_ds_err;

  logic         w_advance;
  logic         w_pc_load;
  logic         w_pc_inc;
  logic [31:0]  w_pc;

  assign w_advance = i_clk_enable & ~i_instr_wait & (r_state != FETCH_HALTED);
  assign w_pc_load = w_advance & (r_state == FETCH_DELAY);
  assign w_pc_inc  = w_advance & (r_state == FETCH_RUN);

  mips_cpu_pc_reg #(
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_reg (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_pc_load),
    .i_load_value (r_pending),
    .i_inc        (w_pc_inc),
    .o_pc         (w_pc)
  );

  // The delay slot always executes; the branch target only takes effect one advancing cycle later.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= FETCH_RUN;
      r_pending <= '0;
      r_ds_err  <= 1'b0;
    end else if (w_advance) begin
      case (r_state)
        FETCH_RUN: begin
          if (i_redirect_valid) begin
            r_pending <= {i_redirect_target[31:2], 2'b00};
            r_state   <= FETCH_DELAY;
          end
        end
        FETCH_DELAY: begin
          if (i_redirect_valid) begin
            r_ds_err <= 1'b1;
          end
          r_state <= (r_pending == HALT_ADDR) ? FETCH_HALTED : FETCH_RUN;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign o_instr_address = w_pc;
  assign o_instr_word    = bswap32(i_instr_readdata);
  assign o_pc_plus8      = w_pc + 32'd8;
  assign o_in_delay_slot = (r_state == FETCH_DELAY);
  assign o_active        = (r_state != FETCH_HALTED);
  assign o_ds_branch_err = r_ds_err;

endmodule

// File: tb/tb_mips_cpu_fetch_unit.sv
// tb/tb_mips_cpu_fetch_unit.sv - directed and randomized bench for mips_cpu_fetch_unit
module tb_mips_cpu_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, ce, wt, rv;
  logic [31:0] rd, tgt;
  logic [31:0] o_addr, o_word, o_p8;
  logic        o_ds, o_act, o_err;

  int total = 0;
  int bad   = 0;

  // Reference: where the CPU is, whether a branch target is owed after the current slot, halted, error.
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_owed;
  bit          m_halted;
  bit          m_err;

  mips_cpu_fetch_unit dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_clk_enable      (ce),
    .i_instr_wait      (wt),
    .i_instr_readdata  (rd),
    .i_redirect_valid  (rv),
    .i_redirect_target (tgt),
    .o_instr_address   (o_addr),
    .o_instr_word      (o_word),
    .o_pc_plus8        (o_p8),
    .o_in_delay_slot   (o_ds),
    .o_active          (o_act),
    .o_ds_branch_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_swap(input logic [31:0] x);
    return ((x >> 24) & 32'hFF) | ((x >> 8) & 32'hFF00) | ((x << 8) & 32'hFF_0000) | (x << 24);
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_pc = RV; m_owed = 0; m_halted = 0; m_err = 0; m_target = 0;
    end else if (ce && !wt && !m_halted) begin
      if (m_owed) begin
        if (rv) m_err = 1;
        m_pc   = m_target;
        m_owed = 0;
        if (m_target == 32'h0) m_halted = 1;
      end else begin
        if (rv) begin
          m_target = tgt & 32'hFFFF_FFFC;
          m_owed   = 1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  o_addr, m_pc);
    chk({tag, ".ds"},    {31'b0, o_ds},  {31'b0, m_owed});
    chk({tag, ".act"},   {31'b0, o_act}, {31'b0, !m_halted});
    chk({tag, ".err"},   {31'b0, o_err}, {31'b0, m_err});
    chk({tag, ".p8"},    o_p8,   m_pc + 32'd8);
    chk({tag, ".word"},  o_word, ref_swap(rd));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; wt = 1'b0; rv = 1'b0; tgt = '0; rd = '0;
    m_pc = RV; m_owed = 0; m_halted = 0; m_err = 0; m_target = 0;
    #2;

    // 1: reset, then sequential fetch
    rst = 1'b0; cyc("t1_rst");
    rst = 1'b1;
    chk("t1_addr0", o_addr, 32'hBFC0_0000);
    for (int i = 0; i < 3; i++) cyc("t1_seq");
    chk("t1_addr3", o_addr, 32'hBFC0_000C);
    chk("t1_act", {31'b0, o_act}, 32'd1);

    // 2: byte swap
    rd = 32'h2000_0124; #1;
    chk("t2_word", o_word, 32'h2401_0020);

    // 3: branch at BFC00008 (restart from reset)
    rst = 1'b0; cyc("t3_rst"); rst = 1'b1;
    cyc("t3_a"); cyc("t3_b");
    chk("t3_at8", o_addr, 32'hBFC0_0008);
    rv = 1'b1; tgt = 32'hBFC0_0018; #1;
    chk("t3_p8", o_p8, 32'hBFC0_0010);
    cyc("t3_br"); rv = 1'b0;
    chk("t3_ds_addr", o_addr, 32'hBFC0_000C);
    chk("t3_ds_flag", {31'b0, o_ds}, 32'd1);
    cyc("t3_tgt");
    chk("t3_tgt_addr", o_addr, 32'hBFC0_0018);

    // 5: stall in delay slot
    rv = 1'b1; tgt = 32'hBFC0_0040; cyc("t5_br"); rv = 1'b0;
    wt = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t5_wait");
    chk("t5_hold_addr", o_addr, 32'hBFC0_001C);
    wt = 1'b0; cyc("t5_resume");
    chk("t5_tgt_addr", o_addr, 32'hBFC0_0040);
    ce = 1'b0; rv = 1'b1; tgt = 32'h1234; cyc("t5_ce0"); ce = 1'b1; rv = 1'b0;

    // 6: redirect inside delay slot, then reset mid-delay with clk_enable low
    rv = 1'b1; tgt = 32'h0000_0083; cyc("t6_br");
    tgt = 32'h0000_0100; cyc("t6_dsbr");
    chk("t6_addr", o_addr, 32'h0000_0080);
    chk("t6_err", {31'b0, o_err}, 32'd1);
    tgt = 32'h0000_0200; cyc("t6_br2"); rv = 1'b0;
    ce = 1'b0; wt = 1'b1; rst = 1'b0; cyc("t6_rst");
    rst = 1'b1; ce = 1'b1; wt = 1'b0;
    chk("t6_rst_addr", o_addr, RV);
    chk("t6_rst_err", {31'b0, o_err}, 32'd0);
    cyc("t6_after");

    // 4: jump to halt address
    while (m_pc != 32'hBFC0_002C) cyc("t4_walk");
    rv = 1'b1; tgt = 32'h0; cyc("t4_br"); rv = 1'b0;
    chk("t4_ds_addr", o_addr, 32'hBFC0_0030);
    cyc("t4_halt");
    chk("t4_halt_act", {31'b0, o_act}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rv = i[0]; tgt = $urandom; cyc("t4_hold");
    end
    rv = 1'b0;
    chk("t4_hold_addr", o_addr, 32'h0);
    chk("t4_no_err", {31'b0, o_err}, 32'd0);

    // wrap: FFFFFFFC + 4 sequentially must not halt
    rst = 1'b0; cyc("w_rst"); rst = 1'b1;
    rv = 1'b1; tgt = 32'hFFFF_FFFB; cyc("w_br"); rv = 1'b0;
    for (int i = 0; i < 4; i++) cyc("w_seq");
    chk("w_addr", o_addr, 32'h0000_0004);
    chk("w_act", {31'b0, o_act}, 32'd1);

    // randomized run against the reference
    for (int i = 0; i < 600; i++) begin
      rst = !(($urandom % 60 == 0) || (m_halted && $urandom % 6 == 0));
      ce  = ($urandom % 8) != 0;
      wt  = ($urandom % 6) == 0;
      rv  = ($urandom % 3) == 0;
      case ($urandom % 10)
        0:       tgt = $urandom % 4;
        1:       tgt = 32'hFFFF_FFF0 | ($urandom % 16);
        default: tgt = $urandom;
      endcase
      rd = $urandom;
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
